filter_manager: RTL and testbench

Capture-and-filter engine between the sample acquisition front end and the display/readout path. On a trigger it records exactly CAPTURE_LENGTH samples from an AXI-Stream-style input into an internal buffer. It then replays the buffer through a 4-tap moving-average filter and emits the results as a burst on an output stream. A new trigger is accepted only once the previous burst has finished.

---
 rtl/filter_manager.sv | 147 ++++++++++++++
 tb/tb_filter_manager.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_manager.sv
// Capture-and-filter engine: records CAPTURE_LENGTH samples, replays them as a burst.
// FILTER_MANAGER_MOVING_AVG_EN enables the 4-tap moving average; otherwise raw replay.
module filter_manager #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH    = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trigger,
    input  logic                         axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                         axiol,
    output logic                         busy,
    output logic                         done
);

    localparam int W  = SAMPLE_DATA_WIDTH;
    localparam int AW = $clog2(CAPTURE_LENGTH);
    localparam logic [AW-1:0] LAST = AW'(CAPTURE_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FILTER,
        DONE
    } state_t;

    state_t state;
    state_t nxt;

    logic [W-1:0]  mem [CAPTURE_LENGTH];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] out_cnt;
    logic          rd_done;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          trig_hold;
    logic          start;
    logic          wr_en;
    logic          wr_last;
    logic          rd_en;
    logic [W-1:0]  result;

    // A trigger still held from the previous run must drop before it counts again
    assign start   = (state == IDLE) && trigger && !trig_hold;
    assign wr_en   = (state == CAPTURE) && axiiv;
    assign wr_last = wr_en && (wr_addr == LAST);
    assign rd_en   = (state == FILTER) && !rd_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = CAPTURE;
            CAPTURE: if (wr_last) nxt = FILTER;
            FILTER:  if (axiov && axiol) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= axiid;
        if (rd_en) rd_data <= mem[rd_addr];
    end

`ifdef FILTER_MANAGER_MOVING_AVG_EN
    logic [W-1:0] t0, t1, t2;
    logic [W+1:0] sum;

    always_comb begin
        sum = {2'b00, rd_data} + {2'b00, t0}
            + {2'b00, t1} + {2'b00, t2};
        result = sum[W+1:2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t0 <= '0;
            t1 <= '0;
            t2 <= '0;
        end else if (state != FILTER) begin
            t0 <= '0;
            t1 <= '0;
            t2 <= '0;
        end else if (rd_valid) begin
            t0 <= rd_data;
            t1 <= t0;
            t2 <= t1;
        end
    end
`else
    assign result = rd_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            rd_done   <= 1'b0;
            rd_valid  <= 1'b0;
            out_cnt   <= '0;
            axiov     <= 1'b0;
            axiod     <= '0;
            axiol     <= 1'b0;
            trig_hold <= 1'b0;
        end else begin
            trig_hold <= trigger && (busy || trig_hold);

            if (start)      wr_addr <= '0;
            else if (wr_en) wr_addr <= wr_addr + 1'b1;

            if (state != FILTER) begin
                rd_addr <= '0;
                rd_done <= 1'b0;
            end else if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
                if (rd_addr == LAST) rd_done <= 1'b1;
            end
            rd_valid <= rd_en;

            axiov <= rd_valid;
            if (rd_valid) begin
                axiod   <= result;
                axiol   <= (out_cnt == LAST);
                out_cnt <= out_cnt + 1'b1;
            end else begin
                axiod <= '0;
                axiol <= 1'b0;
            end
            if (state != FILTER) out_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_filter_manager.sv
// Self-checking bench for filter_manager: table vectors plus scoreboarded bursts.
// Expected data follows FILTER_MANAGER_MOVING_AVG_EN the same way as the design.
module tb_filter_manager;

    localparam int W = 8;
    localparam int L = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         trigger = 1'b0;
    logic         axiiv = 1'b0;
    logic [W-1:0] axiid = '0;
    logic         axiov;
    logic [W-1:0] axiod;
    logic         axiol;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    filter_manager #(
        .SAMPLE_DATA_WIDTH(W),
        .CAPTURE_LENGTH(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trigger(trigger),
        .axiiv(axiiv),
        .axiid(axiid),
        .axiov(axiov),
        .axiod(axiod),
        .axiol(axiol),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    typedef struct {
        logic         trig;
        logic         iv;
        logic [W-1:0] d;
        logic         busy;
        logic         ov;
        logic         done;
    } vec_t;

    exp_t   sbq[$];
    exp_t   e;
    vec_t   vt[6];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     first_ov = -1;
    int     last_ov = -1;
    int     done_cyc = -1;
    int     done_cnt = 0;
    int     ov_cnt = 0;
    int     ov_base = 0;
    int     elast = 0;
    logic   prev_ov = 1'b0;
    logic [W-1:0] m1, m2, m3;
    int     kidx = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (axiov) begin
            if (!prev_ov) first_ov = cyc;
            ov_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_axiov", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("axiod", int'(axiod), int'(e.d));
                chk("axiol", int'(axiol), int'(e.l));
                if (axiol) last_ov = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_ov = axiov;
    end

    task automatic model_reset();
        m1 = '0;
        m2 = '0;
        m3 = '0;
        kidx = 0;
    endtask

    task automatic push_exp(input logic [W-1:0] s);
        exp_t x;
        logic [W+1:0] sum;
        sum = {2'b00, s} + {2'b00, m1} + {2'b00, m2} + {2'b00, m3};
`ifdef FILTER_MANAGER_MOVING_AVG_EN
        x.d = sum[W+1:2];
`else
        x.d = s;
`endif
        x.l = (kidx == L - 1);
        sbq.push_back(x);
        m3 = m2;
        m2 = m1;
        m1 = s;
        kidx++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] s, input int gap);
        axiiv = 1'b1;
        axiid = s;
        push_exp(s);
        tick();
        elast = cyc;
        axiiv = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        model_reset();
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int i;
        start_cnt = done_cnt;
        i = 0;
        while (i < budget && done_cnt == start_cnt) begin
            tick();
            i++;
        end
        chk("done_timeout", int'(done_cnt == start_cnt), 0);
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        #2;
        chk("rst_axiov", int'(axiov), 0);
        chk("rst_axiod", int'(axiod), 0);
        chk("rst_axiol", int'(axiol), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            trigger = vt[i].trig;
            axiiv   = vt[i].iv;
            axiid   = vt[i].d;
            tick();
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].busy));
            chk($sformatf("vec%0d_axiov", i), int'(axiov), int'(vt[i].ov));
            chk($sformatf("vec%0d_done", i), int'(done), int'(vt[i].done));
        end
        trigger = 1'b0;
        axiiv = 1'b0;
        chk("idle_no_axiov", ov_cnt, 0);

        // Burst 1: ramp data, spaced samples
        model_reset();
        for (int i = 0; i < L; i++) send(W'(i), 2);
        wait_done(L + 50);
        chk("b1_busy_after", int'(busy), 0);
        chk("b1_done_cnt", done_cnt, 1);
        chk("b1_ov_cnt", ov_cnt, L);
        chk("b1_no_gaps", last_ov - first_ov, L - 1);
        chk("b1_done_cycle", done_cyc, last_ov + 1);
        chk("b1_sb_empty", sbq.size(), 0);
        chk("b1_latency", first_ov - elast, 2);

        // Trigger in the first IDLE cycle after DONE starts a capture
        pulse_trigger();
        chk("retrigger_busy", int'(busy), 1);
        ov_base = ov_cnt;
        for (int i = 0; i < L; i++) send(W'($urandom), 0);
        repeat (10) tick();
        trigger = 1'b1;
        wait_done(L + 50);
        trigger = 1'b0;
        repeat (5) tick();
        chk("b2_latency", first_ov - elast, 2);
        chk("b2_ov_cnt", ov_cnt - ov_base, L);
        chk("b2_no_gaps", last_ov - first_ov, L - 1);
        chk("b2_one_done", done_cnt, 2);
        chk("b2_trig_ignored", int'(busy), 0);

        // Reset in the middle of a capture
        pulse_trigger();
        for (int i = 0; i < 500; i++) send(W'($urandom), 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_axiov", int'(axiov), 0);
        sbq.delete();
        ov_base = ov_cnt;
        tick();
        rst = 1'b1;
        repeat (1100) tick();
        chk("abort_no_axiov", ov_cnt - ov_base, 0);
        chk("abort_no_done", done_cnt, 2);

        pulse_trigger();
        for (int i = 0; i < L; i++) send(W'($urandom), 3);
        wait_done(L + 50);
        chk("b3_ov_cnt", ov_cnt - ov_base, L);
        chk("b3_done_cnt", done_cnt, 3);
        chk("b3_sb_empty", sbq.size(), 0);
        chk("b3_busy_after", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
